// File: rtl/l1_request_arbiter_rr_if.sv
// Bundle of upstream L1 request channels, the memory-side slot and the return path.
// No logic of its own; widths follow the parameters.
// The slave modport is the arbiter side; the master modport is the requester/memory side.
interface l1_request_arbiter_rr_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BE_W   = DATA_WIDTH / 8;

    // Upstream request channels, port p in slice p
    logic [NUM_PORTS-1:0]            req_request;
    logic [NUM_PORTS-1:0]            req_ack;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_data;
    logic [NUM_PORTS-1:0]            req_rnw;
    logic [NUM_PORTS*BE_W-1:0]       req_be;
    logic [NUM_PORTS*5-1:0]          req_size;
    logic [NUM_PORTS-1:0]            req_is_amo;
    logic [NUM_PORTS*5-1:0]          req_amo;

    // Memory-side request slot
    logic                  mem_request;
    logic                  mem_ack;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_rnw;
    logic [BE_W-1:0]       mem_be;
    logic [4:0]            mem_size;
    logic                  mem_is_amo;
    logic [4:0]            mem_amo;
    logic [PORT_W-1:0]     mem_port_id;

    // Return path
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_rdata_valid;
    logic [DATA_WIDTH-1:0] ret_data;
    logic [NUM_PORTS-1:0]  ret_data_valid;
    logic                  protocol_error;

    modport slave (
        input  req_request, req_addr, req_data, req_rnw, req_be, req_size, req_is_amo, req_amo,
        output req_ack,
        output mem_request, mem_addr, mem_data, mem_rnw, mem_be, mem_size, mem_is_amo, mem_amo,
        output mem_port_id,
        input  mem_ack, mem_rdata, mem_rdata_valid,
        output ret_data, ret_data_valid, protocol_error
    );

    modport master (
        output req_request, req_addr, req_data, req_rnw, req_be, req_size, req_is_amo, req_amo,
        input  req_ack,
        input  mem_request, mem_addr, mem_data, mem_rnw, mem_be, mem_size, mem_is_amo, mem_amo,
        input  mem_port_id,
        output mem_ack, mem_rdata, mem_rdata_valid,
        input  ret_data, ret_data_valid, protocol_error
    );
endinterface

// File: rtl/l1_request_arbiter_rr.sv
// Round-robin merge of NUM_PORTS L1 request channels onto one registered memory slot, with in-order read return routing.
// Latency: request to mem_request 1 cycle when the slot is free; return beats routed combinationally (0 cycles).
// Backpressure: slot holds until mem_ack (mem_ack frees it same cycle); reads stall while the tracking FIFO is full.
module l1_request_arbiter_rr #(
    parameter int NUM_PORTS       = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk,
    input  logic rst,
    l1_request_arbiter_rr_if.slave bus
);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int AW     = $clog2(MAX_OUTSTANDING);
    localparam int CW     = AW + 1;

    // Arbitration and slot state
    logic [PORT_W-1:0]     r_ptr;
    logic                  r_mem_request;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_rnw;
    logic [BE_W-1:0]       r_be;
    logic [4:0]            r_size;
    logic                  r_is_amo;
    logic [4:0]            r_amo;
    logic [PORT_W-1:0]     r_port_id;

    // Read tracking FIFO: source port and expected beat count per outstanding read
    logic [PORT_W-1:0]     r_trk_port  [MAX_OUTSTANDING];
    logic [5:0]            r_trk_beats [MAX_OUTSTANDING];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [5:0]            r_beat_cnt;
    logic                  r_protocol_error;

    logic                  w_slot_free;
    logic                  w_full;
    logic                  w_empty;
    logic [NUM_PORTS-1:0]  w_eligible;
    logic                  w_found;
    logic [PORT_W-1:0]     w_grant_idx;
    logic [PORT_W:0]       w_scan;
    logic                  w_grant;
    logic [PORT_W-1:0]     w_ptr_next;
    logic [NUM_PORTS-1:0]  w_req_ack;
    logic [ADDR_WIDTH-1:0] w_g_addr;
    logic [DATA_WIDTH-1:0] w_g_data;
    logic                  w_g_rnw;
    logic [BE_W-1:0]       w_g_be;
    logic [4:0]            w_g_size;
    logic                  w_g_is_amo;
    logic [4:0]            w_g_amo;
    logic                  w_push;
    logic [5:0]            w_push_beats;
    logic [PORT_W-1:0]     w_head_port;
    logic [5:0]            w_head_beats;
    logic                  w_ret_vld;
    logic                  w_pop;
    logic [NUM_PORTS-1:0]  w_ret_data_valid;

    // Slot can take a new request when empty or being drained this cycle
    assign w_slot_free = ~r_mem_request | bus.mem_ack;
    // Full/empty use the registered count only, so a same-cycle pop never admits a read
    assign w_full      = (r_count == CW'(MAX_OUTSTANDING));
    assign w_empty     = (r_count == '0);

    // Writes are always eligible; reads (including AMOs) need tracking space
    always_comb begin
        w_eligible = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_eligible[p] = bus.req_request[p] &
                            (~(bus.req_rnw[p] | bus.req_is_amo[p]) | ~w_full);
        end
    end

    // First eligible port starting at the priority pointer, wrapping modulo NUM_PORTS
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_scan      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_scan = {1'b0, r_ptr} + (PORT_W+1)'(i);
            if (w_scan >= (PORT_W+1)'(NUM_PORTS)) begin
                w_scan = w_scan - (PORT_W+1)'(NUM_PORTS);
            end
            if (!w_found && w_eligible[w_scan[PORT_W-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_scan[PORT_W-1:0];
            end
        end
    end

    assign w_grant    = w_slot_free & w_found & ~rst;
    assign w_ptr_next = (w_grant_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : (w_grant_idx + PORT_W'(1));

    // Select the winner's request fields and raise its one-cycle ack
    always_comb begin
        w_g_addr   = '0;
        w_g_data   = '0;
        w_g_rnw    = 1'b0;
        w_g_be     = '0;
        w_g_size   = '0;
        w_g_is_amo = 1'b0;
        w_g_amo    = '0;
        w_req_ack  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_grant_idx == PORT_W'(p)) begin
                w_g_addr   = bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                w_g_data   = bus.req_data[p*DATA_WIDTH +: DATA_WIDTH];
                w_g_rnw    = bus.req_rnw[p];
                w_g_be     = bus.req_be[p*BE_W +: BE_W];
                w_g_size   = bus.req_size[p*5 +: 5];
                w_g_is_amo = bus.req_is_amo[p];
                w_g_amo    = bus.req_amo[p*5 +: 5];
                w_req_ack[p] = w_grant;
            end
        end
    end

    // An AMO returns a single beat whatever its size field says
    assign w_push       = w_grant & (w_g_rnw | w_g_is_amo);
    assign w_push_beats = w_g_is_amo ? 6'd1 : ({1'b0, w_g_size} + 6'd1);

    assign w_head_port  = r_trk_port[r_rd_ptr];
    assign w_head_beats = r_trk_beats[r_rd_ptr];
    assign w_ret_vld    = bus.mem_rdata_valid & ~w_empty;
    assign w_pop        = w_ret_vld & ((r_beat_cnt + 6'd1) == w_head_beats);

    // Steer each return beat to the port at the head of the tracking FIFO
    always_comb begin
        w_ret_data_valid = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_ret_data_valid[p] = w_ret_vld & (w_head_port == PORT_W'(p));
        end
    end

    // Control state: slot valid, pointer, FIFO pointers/count, beat counter, sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_request    <= 1'b0;
            r_ptr            <= '0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_beat_cnt       <= '0;
            r_protocol_error <= 1'b0;
        end else begin
            if (w_slot_free) begin
                r_mem_request <= w_found;
            end
            if (w_grant) begin
                r_ptr <= w_ptr_next;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_ret_vld) begin
                r_beat_cnt <= w_pop ? 6'd0 : (r_beat_cnt + 6'd1);
            end
            if (bus.mem_rdata_valid && w_empty) begin
                r_protocol_error <= 1'b1;
            end
        end
    end

    // Datapath: slot fields and FIFO entries, meaningful only while their valid state says so
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_addr    <= w_g_addr;
            r_data    <= w_g_data;
            r_rnw     <= w_g_rnw;
            r_be      <= w_g_be;
            r_size    <= w_g_size;
            r_is_amo  <= w_g_is_amo;
            r_amo     <= w_g_amo;
            r_port_id <= w_grant_idx;
        end
        if (w_push) begin
            r_trk_port[r_wr_ptr]  <= w_grant_idx;
            r_trk_beats[r_wr_ptr] <= w_push_beats;
        end
    end

    assign bus.req_ack        = w_req_ack;
    assign bus.mem_request    = r_mem_request;
    assign bus.mem_addr       = r_addr;
    assign bus.mem_data       = r_data;
    assign bus.mem_rnw        = r_rnw;
    assign bus.mem_be         = r_be;
    assign bus.mem_size       = r_size;
    assign bus.mem_is_amo     = r_is_amo;
    assign bus.mem_amo        = r_amo;
    assign bus.mem_port_id    = r_port_id;
    assign bus.ret_data       = bus.mem_rdata;
    assign bus.ret_data_valid = w_ret_data_valid;
    assign bus.protocol_error = r_protocol_error;
endmodule

// File: tb/tb_l1_request_arbiter_rr.sv
// Self-checking bench for l1_request_arbiter_rr: vector table, directed corner sequences, random run vs. queue model.
// Inputs driven 1 time unit after posedge; outputs sampled on negedge.
// Memory side randomly withholds mem_ack; return beats only while the model has reads outstanding.
module tb_l1_request_arbiter_rr;
    localparam int NP   = 4;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l1_request_arbiter_rr_if #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    l1_request_arbiter_rr #(
        .NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] req;
        logic       mack;
        logic [3:0] exp_ack;
        logic       exp_mreq;
        int         exp_id;
    } vec_t;
    vec_t tbl[15];

    typedef struct { int port; int beats; } trk_t;
    trk_t mq[$];

    // Random-phase model state
    int          m_ptr, m_cnt, m_sport, g, cand;
    bit          m_sv, m_err, free, full;
    logic [31:0] m_saddr, m_sdata;
    logic [4:0]  m_ssize;
    bit          m_srnw, m_samo;
    bit          pend[NP];
    bit          prnw[NP], pamo[NP];
    logic [4:0]  psz[NP];
    logic [31:0] pa[NP], pd[NP];
    logic [3:0]  eack, eret, mask;
    logic [31:0] rdat;
    int          exp_ports[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int p, input bit rnw, input bit amo, input logic [4:0] size,
                              input logic [31:0] addr, input logic [31:0] data);
        bus.req_rnw[p]          = rnw;
        bus.req_is_amo[p]       = amo;
        bus.req_size[p*5 +: 5]  = size;
        bus.req_addr[p*32 +: 32] = addr;
        bus.req_data[p*32 +: 32] = data;
        bus.req_be[p*4 +: 4]    = 4'hF;
        bus.req_amo[p*5 +: 5]   = amo ? 5'd3 : 5'd0;
    endtask

    // Present a single request on port p, expect it acked this cycle, then withdraw it
    task automatic issue(input int p, input bit rnw, input bit amo, input logic [4:0] size,
                         input logic [31:0] addr, input logic [31:0] data);
        set_fields(p, rnw, amo, size, addr, data);
        bus.req_request    = '0;
        bus.req_request[p] = 1'b1;
        @(negedge clk);
        chk($sformatf("issue_ack_p%0d", p), bus.req_ack, 64'(4'b0001 << p));
        step();
        bus.req_request[p] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_request = '0; bus.req_addr = '0; bus.req_data = '0; bus.req_rnw = '0;
        bus.req_be = '0; bus.req_size = '0; bus.req_is_amo = '0; bus.req_amo = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.mem_rdata_valid = 1'b0;

        // Round-robin / slot-hold vectors, all writes so tracking never matters
        tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0, -1};
        tbl[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1,  0};
        tbl[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1,  1};
        tbl[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1,  2};
        tbl[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1,  3};
        tbl[5]  = '{4'hF, 1'b1, 4'b0010, 1'b1,  0};
        tbl[6]  = '{4'hA, 1'b1, 4'b1000, 1'b1,  1};
        tbl[7]  = '{4'hA, 1'b1, 4'b0010, 1'b1,  3};
        tbl[8]  = '{4'h0, 1'b1, 4'b0000, 1'b1,  1};
        tbl[9]  = '{4'h0, 1'b1, 4'b0000, 1'b0, -1};
        tbl[10] = '{4'h1, 1'b0, 4'b0001, 1'b0, -1};
        tbl[11] = '{4'h4, 1'b0, 4'b0000, 1'b1,  0};
        tbl[12] = '{4'h4, 1'b1, 4'b0100, 1'b1,  0};
        tbl[13] = '{4'h0, 1'b1, 4'b0000, 1'b1,  2};
        tbl[14] = '{4'h0, 1'b1, 4'b0000, 1'b0, -1};

        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_request", bus.mem_request, 0);
        chk("rst_req_ack", bus.req_ack, 0);
        chk("rst_ret_valid", bus.ret_data_valid, 0);
        chk("rst_protocol_error", bus.protocol_error, 0);
        step();

        for (int p = 0; p < NP; p++) set_fields(p, 1'b0, 1'b0, 5'd0, 32'h1000 + 32'(16*p), 32'(p));
        for (int i = 0; i < 15; i++) begin
            bus.req_request = tbl[i].req;
            bus.mem_ack     = tbl[i].mack;
            @(negedge clk);
            chk($sformatf("tbl%0d_ack", i), bus.req_ack, tbl[i].exp_ack);
            chk($sformatf("tbl%0d_mreq", i), bus.mem_request, tbl[i].exp_mreq);
            if (tbl[i].exp_id >= 0) begin
                chk($sformatf("tbl%0d_id", i), bus.mem_port_id, tbl[i].exp_id);
                chk($sformatf("tbl%0d_addr", i), bus.mem_addr, 32'h1000 + 32'(16*tbl[i].exp_id));
            end
            step();
        end
        bus.req_request = '0;
        bus.mem_ack     = 1'b1;

        // Single read, port 2, four beats
        issue(2, 1'b1, 1'b0, 5'd3, 32'h100, 32'h0);
        @(negedge clk);
        chk("rd_mreq", bus.mem_request, 1);
        chk("rd_port_id", bus.mem_port_id, 2);
        chk("rd_addr", bus.mem_addr, 32'h100);
        chk("rd_size", bus.mem_size, 3);
        chk("rd_rnw", bus.mem_rnw, 1);
        step();
        for (int k = 0; k < 4; k++) begin
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata       = 32'hA0 + 32'(k);
            @(negedge clk);
            chk($sformatf("rd_beat%0d_valid", k), bus.ret_data_valid, 4'b0100);
            chk($sformatf("rd_beat%0d_data", k), bus.ret_data, 32'hA0 + 32'(k));
            step();
        end
        bus.mem_rdata_valid = 1'b0;
        @(negedge clk);
        chk("rd_done_valid", bus.ret_data_valid, 0);
        chk("rd_done_mreq", bus.mem_request, 0);
        step();

        // Tracking full: four reads outstanding, then read on 1 and write on 3
        for (int k = 0; k < 4; k++) issue(0, 1'b1, 1'b0, 5'd0, 32'h200 + 32'(k), 32'h0);
        set_fields(1, 1'b1, 1'b0, 5'd0, 32'h300, 32'h0);
        set_fields(3, 1'b0, 1'b0, 5'd0, 32'h304, 32'h55);
        bus.req_request = 4'b1010;
        @(negedge clk);
        chk("full_write_only", bus.req_ack, 4'b1000);
        step();
        bus.req_request = 4'b0010;
        @(negedge clk);
        chk("full_read_blocked", bus.req_ack, 0);
        step();
        bus.mem_rdata_valid = 1'b1;
        @(negedge clk);
        chk("full_pop_cycle_ack", bus.req_ack, 0);
        chk("full_pop_route", bus.ret_data_valid, 4'b0001);
        step();
        bus.mem_rdata_valid = 1'b0;
        @(negedge clk);
        chk("full_after_pop_ack", bus.req_ack, 4'b0010);
        step();
        bus.req_request = '0;
        exp_ports = '{0, 0, 0, 1};
        for (int k = 0; k < 4; k++) begin
            bus.mem_rdata_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("full_drain%0d", k), bus.ret_data_valid, 64'(4'b0001 << exp_ports[k]));
            step();
        end
        bus.mem_rdata_valid = 1'b0;

        // Backpressure on port 0 writes
        bus.mem_ack = 1'b0;
        set_fields(0, 1'b0, 1'b0, 5'd0, 32'h200, 32'hDEAD);
        bus.req_request = 4'b0001;
        @(negedge clk);
        chk("bp_first_ack", bus.req_ack, 4'b0001);
        step();
        set_fields(0, 1'b0, 1'b0, 5'd0, 32'h204, 32'hBEEF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_mreq", k), bus.mem_request, 1);
            chk($sformatf("bp_hold%0d_addr", k), bus.mem_addr, 32'h200);
            chk($sformatf("bp_hold%0d_data", k), bus.mem_data, 32'hDEAD);
            chk($sformatf("bp_hold%0d_ack", k), bus.req_ack, 0);
            step();
        end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        chk("bp_release_ack", bus.req_ack, 4'b0001);
        step();
        bus.req_request = '0;
        @(negedge clk);
        chk("bp_next_addr", bus.mem_addr, 32'h204);
        chk("bp_next_data", bus.mem_data, 32'hBEEF);
        step();

        // AMO (one beat regardless of size) followed by a two-beat read
        issue(1, 1'b0, 1'b1, 5'd7, 32'h400, 32'h9);
        issue(0, 1'b1, 1'b0, 5'd1, 32'h500, 32'h0);
        exp_ports = '{1, 0, 0, 0};
        for (int k = 0; k < 3; k++) begin
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata       = 32'h11 * 32'(k + 1);
            @(negedge clk);
            chk($sformatf("amo_ret%0d", k), bus.ret_data_valid, 64'(4'b0001 << exp_ports[k]));
            step();
        end
        bus.mem_rdata_valid = 1'b0;

        // Stray beat with nothing outstanding
        bus.mem_rdata_valid = 1'b1;
        @(negedge clk);
        chk("err_route_none", bus.ret_data_valid, 0);
        step();
        bus.mem_rdata_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("err_sticky%0d", k), bus.protocol_error, 1);
            step();
        end
        issue(2, 1'b0, 1'b0, 5'd0, 32'h600, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_protocol_error", bus.protocol_error, 0);
        chk("rst2_mem_request", bus.mem_request, 0);
        set_fields(1, 1'b0, 1'b0, 5'd0, 32'h700, 32'h2);
        set_fields(3, 1'b0, 1'b0, 5'd0, 32'h704, 32'h3);
        step();
        bus.req_request = 4'b1010;
        @(negedge clk);
        chk("rst2_first_grant", bus.req_ack, 4'b0010);
        step();
        bus.req_request = '0;

        // Random traffic against a queue-based model
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_ptr = 0; m_cnt = 0; m_sv = 0; m_err = 0; m_sport = 0;
        m_saddr = '0; m_sdata = '0; m_ssize = '0; m_srnw = 0; m_samo = 0;
        mq.delete();
        for (int p = 0; p < NP; p++) pend[p] = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) begin
                    pend[p] = 1;
                    pamo[p] = ($urandom_range(0, 4) == 0);
                    prnw[p] = ($urandom_range(0, 1) == 1);
                    psz[p]  = pamo[p] ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
                    pa[p]   = $urandom;
                    pd[p]   = $urandom;
                    set_fields(p, prnw[p], pamo[p], psz[p], pa[p], pd[p]);
                end
            end
            mask = '0;
            for (int p = 0; p < NP; p++) mask[p] = pend[p];
            bus.req_request     = mask;
            bus.mem_ack         = ($urandom_range(0, 3) != 0);
            bus.mem_rdata_valid = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            rdat                = $urandom;
            bus.mem_rdata       = rdat;

            free = !m_sv || bus.mem_ack;
            full = (mq.size() == MAXO);
            g = -1;
            for (int i = 0; i < NP; i++) begin
                cand = (m_ptr + i) % NP;
                if (g < 0 && pend[cand] && (!(prnw[cand] || pamo[cand]) || !full)) g = cand;
            end
            eack = (free && g >= 0) ? (4'b0001 << g) : 4'b0000;
            eret = (bus.mem_rdata_valid && mq.size() > 0) ? (4'b0001 << mq[0].port) : 4'b0000;

            @(negedge clk);
            chk("rnd_ack", bus.req_ack, eack);
            chk("rnd_ret_valid", bus.ret_data_valid, eret);
            if (eret != 0) chk("rnd_ret_data", bus.ret_data, rdat);
            chk("rnd_mreq", bus.mem_request, m_sv);
            chk("rnd_err", bus.protocol_error, m_err);
            if (m_sv) begin
                chk("rnd_port_id", bus.mem_port_id, m_sport);
                chk("rnd_addr", bus.mem_addr, m_saddr);
                chk("rnd_data", bus.mem_data, m_sdata);
                chk("rnd_size", bus.mem_size, m_ssize);
                chk("rnd_rnw", bus.mem_rnw, m_srnw);
                chk("rnd_amo", bus.mem_is_amo, m_samo);
            end

            if (bus.mem_rdata_valid) begin
                if (mq.size() == 0) m_err = 1;
                else begin
                    m_cnt++;
                    if (m_cnt == mq[0].beats) begin
                        mq.delete(0);
                        m_cnt = 0;
                    end
                end
            end
            if (eack != 0) begin
                if (prnw[g] || pamo[g]) mq.push_back('{g, pamo[g] ? 1 : int'(psz[g]) + 1});
                m_sv = 1; m_sport = g; m_saddr = pa[g]; m_sdata = pd[g];
                m_ssize = psz[g]; m_srnw = prnw[g]; m_samo = pamo[g];
                m_ptr = (g + 1) % NP;
                pend[g] = 0;
            end else if (free) begin
                m_sv = 0;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/l1_request_arbiter_rr.md
Name: l1_request_arbiter_rr

Overview:
- Parametrised N-port arbiter that merges NUM_PORTS L1 request channels (addr/data/rnw/be/size/is_amo/amo, request/ack semantics) onto one registered memory-side request channel.
- Uses round-robin fairness.
- Records each read's source port and beat count in an in-order tracking FIFO, and routes returned data beats back to the originating port.
- Sits between the L1 caches/units and the L2 or external bus bridge.

Parameters:
- NUM_PORTS, 4, number of upstream request channels (2..8).
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, request/return data width; be width = DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, tracking FIFO depth (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_request  in  NUM_PORTS  per-port request valid
- req_ack  out  NUM_PORTS  per-port acceptance pulse
- req_addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_PORTS*DATA_WIDTH  packed write data
- req_rnw  in  NUM_PORTS  read-not-write
- req_be  in  NUM_PORTS*DATA_WIDTH/8  byte enables
- req_size  in  NUM_PORTS*5  burst length minus one, in words
- req_is_amo  in  NUM_PORTS  atomic flag
- req_amo  in  NUM_PORTS*5  atomic opcode
- mem_request  out  1  output slot valid
- mem_ack  in  1  downstream accepts the slot this cycle
- mem_addr, mem_data, mem_rnw, mem_be, mem_size, mem_is_amo, mem_amo  out  per-field widths  registered copy of the granted request
- mem_port_id  out  $clog2(NUM_PORTS)  source port of the slot
- mem_rdata  in  DATA_WIDTH  return data beat
- mem_rdata_valid  in  1  return beat valid; no backpressure
- ret_data  out  DATA_WIDTH  return data broadcast to all ports
- ret_data_valid  out  NUM_PORTS  one-hot return valid
- protocol_error  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - mem_request=0, req_ack=0, ret_data_valid=0, protocol_error=0.
  - Tracking FIFO empty; beat counter=0; priority pointer=0.
  - mem_* data fields are don't-care while mem_request=0.
- Upstream handshake:
  - A port holds request and its fields stable until req_ack.
  - req_ack is a single-cycle pulse. The port may drop request, or present a new request, in the following cycle.
- Slot free: slot_free = !mem_request | mem_ack. This is a combinational path from mem_ack to req_ack, which allows back-to-back grants.
- Eligibility:
  - A port is eligible if req_request[p]=1 and either it is a write, or the tracking FIFO is not full.
  - A read is req_rnw=1 or req_is_amo=1.
  - Full is computed from the registered count only; a same-cycle pop does not free space.
- Grant:
  - Grant occurs when slot_free and at least one port is eligible.
  - Winner g is the first eligible port searching pointer, pointer+1, ..., wrapping modulo NUM_PORTS.
  - In the grant cycle: req_ack[g]=1 combinationally. The slot registers g's fields and mem_port_id=g, and mem_request=1 from the next cycle.
  - Pointer becomes (g+1) mod NUM_PORTS.
- Slot with no grant: if slot_free and no port is eligible, mem_request goes 0 next cycle.
- Downstream: mem_request and the slot fields stay stable until mem_ack. Latency from request to mem_request is 1 cycle when the slot is free.
- Tracking push: on a read grant, push {g, beats}.
  - beats = req_size+1 for a plain read (1..32).
  - beats = 1 for an AMO, regardless of size.
  - Writes push nothing.
- Return routing: each mem_rdata_valid beat produces ret_data=mem_rdata and ret_data_valid[head.port]=1 in the same cycle (combinational, zero latency).
  - The beat counter increments per beat.
  - When counter+1 == head.beats: pop the FIFO and clear the counter.
- Simultaneous push and pop: allowed; the count is unchanged.
- Empty-FIFO beat: mem_rdata_valid while the FIFO is empty routes nowhere (ret_data_valid=0) and sets protocol_error.
- protocol_error is held until rst.
- Reset mid-operation: all state is cleared. The downstream side must be reset in the same cycle; returns after reset with an empty FIFO flag protocol_error.
- NUM_PORTS=1: the pointer is constant 0 and mem_port_id is 1 bit, tied to 0.

Test Plan:
- Single read: port 2 reads addr 0x100, size 3; mem_ack on the first cycle; 4 beats 0xA0..0xA3 returned.
  - Expect req_ack[2] one cycle, mem_request the next cycle with mem_port_id=2.
  - Expect ret_data_valid=4'b0100 for exactly 4 beats, then FIFO empty.
- Round robin: all 4 ports request writes continuously with mem_ack tied 1.
  - Expect grant order 0,1,2,3,0,1 with one grant per cycle, no port acked twice before every other requesting port is acked once.
- Tracking full:
  - Issue 4 reads, size 0, with no returns.
  - Present a read on port 1 and a write on port 3; expect only port 3 acked.
  - After one return beat (pop), port 1 is acked on a later cycle, not the pop cycle.
- Backpressure: hold mem_ack=0 for 5 cycles with port 0 requesting.
  - Expect mem_request and fields stable throughout and no further req_ack.
  - On mem_ack=1, the next grant happens in the same cycle.
- AMO plus interleaved returns:
  - Port 1 issues an AMO with size=7, then port 0 reads size 1.
  - Returns 0x11, 0x22, 0x33 must go to ports 1, 0, 0 respectively.
- Error and reset:
  - A return beat with the FIFO empty sets protocol_error=1, held for 10 cycles.
  - Pulse rst for 1 cycle: protocol_error=0, mem_request=0, pointer=0, and the first grant goes to the lowest eligible port.
